// File: rtl/id_ex_stage_buf_pkg.sv
// Shared pipeline package for the stage buffers (IF/ID, ID/EX, EX/MEM, MEM/WB).
// Contents:
//   PIPE_DATA_W / PIPE_CTRL_W / PIPE_RA_W  default field widths
//   occ_state_e                            stage occupancy state
//   entry_width()                          packed width of one ID/EX entry
package id_ex_stage_buf_pkg;

   localparam int unsigned PIPE_DATA_W = 32;
   localparam int unsigned PIPE_CTRL_W = 9;
   localparam int unsigned PIPE_RA_W   = 5;

   // OCC_MAIN: only the main register holds an entry.
   // OCC_FULL: main and skid both hold entries.
   typedef enum logic [1:0] {
      OCC_EMPTY = 2'd0,
      OCC_MAIN  = 2'd1,
      OCC_FULL  = 2'd2
   } occ_state_e;

   // ctrl + npc + rs + rt + imm + rt_addr + rd_addr
   function automatic int unsigned entry_width(input int unsigned data_w,
                                               input int unsigned ctrl_w,
                                               input int unsigned ra_w);
      return ctrl_w + 4 * data_w + 2 * ra_w;
   endfunction

endpackage

// File: rtl/id_ex_stage_buf_if.sv
// ID/EX stage bus: upstream (ID) handshake + payload, downstream (EX)
// handshake + payload, flush and occupancy.
// Modports:
//   slave  - the stage buffer (accepts from ID, presents to EX)
//   master - the environment driving ID side and sinking EX side
interface id_ex_stage_buf_if
   import id_ex_stage_buf_pkg::*;
#(
   parameter int unsigned DATA_W = PIPE_DATA_W,
   parameter int unsigned CTRL_W = PIPE_CTRL_W,
   parameter int unsigned RA_W   = PIPE_RA_W
);

   logic              flush;

   logic              in_valid;
   logic              in_ready;
   logic [CTRL_W-1:0] in_ctrl;
   logic [DATA_W-1:0] in_npc;
   logic [DATA_W-1:0] in_rs;
   logic [DATA_W-1:0] in_rt;
   logic [DATA_W-1:0] in_imm;
   logic [RA_W-1:0]   in_rt_addr;
   logic [RA_W-1:0]   in_rd_addr;

   logic              out_valid;
   logic              out_ready;
   logic [CTRL_W-1:0] out_ctrl;
   logic [DATA_W-1:0] out_npc;
   logic [DATA_W-1:0] out_rs;
   logic [DATA_W-1:0] out_rt;
   logic [DATA_W-1:0] out_imm;
   logic [RA_W-1:0]   out_rt_addr;
   logic [RA_W-1:0]   out_rd_addr;

   logic [1:0]        occupancy;

   modport slave (
      input  flush,
      input  in_valid, in_ctrl, in_npc, in_rs, in_rt, in_imm, in_rt_addr, in_rd_addr,
      output in_ready,
      output out_valid, out_ctrl, out_npc, out_rs, out_rt, out_imm, out_rt_addr, out_rd_addr,
      input  out_ready,
      output occupancy
   );

   modport master (
      output flush,
      output in_valid, in_ctrl, in_npc, in_rs, in_rt, in_imm, in_rt_addr, in_rd_addr,
      input  in_ready,
      input  out_valid, out_ctrl, out_npc, out_rs, out_rt, out_imm, out_rt_addr, out_rd_addr,
      output out_ready,
      input  occupancy
   );

endinterface

// File: rtl/id_ex_stage_buf_stage_entry_reg.sv
// stage_entry_reg: one payload register of a stage buffer.
// Ports:
//   clk, reset - clock, asynchronous active-high reset (clears payload)
//   load       - capture d on the rising edge
//   d / q      - payload in / held payload
module stage_entry_reg #(
   parameter int unsigned W = 1
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   logic [W-1:0] entry_q;
   logic [W-1:0] entry_d;

   always_comb begin
      entry_d = entry_q;
      if (load) entry_d = d;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) entry_q <= '0;
      else       entry_q <= entry_d;
   end

   assign q = entry_q;

endmodule

// File: rtl/id_ex_stage_buf.sv
// id_ex_stage_buf: ID/EX pipeline register built as a two-entry skid buffer.
// Ports:
//   clk   - clock, rising edge
//   reset - asynchronous, active-high; empties the stage and zeroes payload
//   bus   - id_ex_stage_buf_if.slave: flush, in_* (from ID), out_* (to EX),
//           occupancy
// The main register drives out_*; the skid register catches the entry that
// arrives while main is stalled. in_ready is decoded from the state register
// only, so out_ready never reaches in_ready combinationally.
module id_ex_stage_buf
   import id_ex_stage_buf_pkg::*;
#(
   parameter int unsigned DATA_W = PIPE_DATA_W,
   parameter int unsigned CTRL_W = PIPE_CTRL_W,
   parameter int unsigned RA_W   = PIPE_RA_W
) (
   input  logic             clk,
   input  logic             reset,
   id_ex_stage_buf_if.slave bus
);

   localparam int unsigned ENTRY_W = entry_width(DATA_W, CTRL_W, RA_W);

   occ_state_e state_q;
   occ_state_e state_d;

   logic main_valid;
   logic skid_valid;
   logic accept;
   logic consume;
   logic main_load;
   logic skid_load;

   logic [ENTRY_W-1:0] in_entry;
   logic [ENTRY_W-1:0] main_next;
   logic [ENTRY_W-1:0] main_entry;
   logic [ENTRY_W-1:0] skid_entry;
   logic [CTRL_W-1:0]  main_ctrl;

   assign in_entry = {bus.in_ctrl, bus.in_npc, bus.in_rs, bus.in_rt, bus.in_imm,
                      bus.in_rt_addr, bus.in_rd_addr};

   assign main_valid = (state_q != OCC_EMPTY);
   assign skid_valid = (state_q == OCC_FULL);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= OCC_EMPTY;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d   = state_q;
      main_load = 1'b0;
      skid_load = 1'b0;
      main_next = in_entry;
      accept    = bus.in_valid & ~skid_valid;
      consume   = main_valid & bus.out_ready;

      // Flush wins over accept and consume; payload registers simply hold.
      if (bus.flush) begin
         state_d = OCC_EMPTY;
      end else begin
         unique case (state_q)
            OCC_EMPTY: begin
               if (accept) begin
                  main_load = 1'b1;
                  state_d   = OCC_MAIN;
               end
            end
            OCC_MAIN: begin
               if (consume) begin
                  if (accept) main_load = 1'b1;
                  else        state_d   = OCC_EMPTY;
               end else if (accept) begin
                  skid_load = 1'b1;
                  state_d   = OCC_FULL;
               end
            end
            OCC_FULL: begin
               // in_ready is low here, so only skid can refill main.
               if (consume) begin
                  main_load = 1'b1;
                  main_next = skid_entry;
                  state_d   = OCC_MAIN;
               end
            end
            default: state_d = OCC_EMPTY;
         endcase
      end
   end

   stage_entry_reg #(.W(ENTRY_W)) u_main (
      .clk   (clk),
      .reset (reset),
      .load  (main_load),
      .d     (main_next),
      .q     (main_entry)
   );

   stage_entry_reg #(.W(ENTRY_W)) u_skid (
      .clk   (clk),
      .reset (reset),
      .load  (skid_load),
      .d     (in_entry),
      .q     (skid_entry)
   );

   assign {main_ctrl, bus.out_npc, bus.out_rs, bus.out_rt, bus.out_imm,
           bus.out_rt_addr, bus.out_rd_addr} = main_entry;

   // Bubble presents as NOP; data fields keep their last value.
   assign bus.out_ctrl  = main_valid ? main_ctrl : '0;
   assign bus.out_valid = main_valid;
   assign bus.in_ready  = ~skid_valid;
   assign bus.occupancy = {1'b0, main_valid} + {1'b0, skid_valid};

endmodule

// File: tb/tb_id_ex_stage_buf.sv
module tb_id_ex_stage_buf;

   typedef struct packed {
      logic [8:0]  ctrl;
      logic [31:0] npc;
      logic [31:0] rs;
      logic [31:0] rt;
      logic [31:0] imm;
      logic [4:0]  rt_a;
      logic [4:0]  rd_a;
   } ent_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   id_ex_stage_buf_if bus ();

   id_ex_stage_buf #(.DATA_W(32), .CTRL_W(9), .RA_W(5)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int   n_checks = 0;
   int   n_fail   = 0;
   ent_t exp_q[$];   // reference: FIFO of entries held by the stage, capacity 2
   logic pend = 1'b0;
   ent_t pend_e;

   task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic ent_t rand_ent();
      ent_t e;
      e.ctrl = 9'($urandom);
      e.npc  = $urandom;
      e.rs   = $urandom;
      e.rt   = $urandom;
      e.imm  = $urandom;
      e.rt_a = 5'($urandom);
      e.rd_a = 5'($urandom);
      return e;
   endfunction

   function automatic ent_t out_ent();
      ent_t e;
      e = {bus.out_ctrl, bus.out_npc, bus.out_rs, bus.out_rt, bus.out_imm,
           bus.out_rt_addr, bus.out_rd_addr};
      return e;
   endfunction

   // Drive inputs for the coming edge and note whether the handshake will fire.
   task automatic apply(input logic v, input ent_t e, input logic ordy, input logic fl);
      bus.in_valid   = v;
      bus.in_ctrl    = e.ctrl;
      bus.in_npc     = e.npc;
      bus.in_rs      = e.rs;
      bus.in_rt      = e.rt;
      bus.in_imm     = e.imm;
      bus.in_rt_addr = e.rt_a;
      bus.in_rd_addr = e.rd_a;
      bus.out_ready  = ordy;
      bus.flush      = fl;
      #1;
      pend   = v && bus.in_ready && !fl && !reset;
      pend_e = e;
   endtask

   task automatic step(input logic v, input ent_t e, input logic ordy, input logic fl);
      @(posedge clk);
      if (pend) exp_q.push_back(pend_e);
      pend = 1'b0;
      #1;
      apply(v, e, ordy, fl);
   endtask

   // Monitor: compare presented state against the reference FIFO, retire on consume.
   always @(negedge clk) begin
      if (!reset) begin
         chk("occupancy", 160'(bus.occupancy), 160'(exp_q.size()));
         chk("in_ready",  160'(bus.in_ready),  160'(exp_q.size() < 2));
         chk("out_valid", 160'(bus.out_valid), 160'(exp_q.size() > 0));
         if (exp_q.size() > 0) begin
            chk("out_entry", 160'(out_ent()), 160'(exp_q[0]));
         end else begin
            chk("bubble_ctrl", 160'(bus.out_ctrl), 160'(0));
         end
         if (bus.flush) begin
            exp_q.delete();
         end else if (bus.out_valid && bus.out_ready && exp_q.size() > 0) begin
            void'(exp_q.pop_front());
         end
      end
   end

   initial begin
      ent_t z, a, b, c;
      z = '0;
      apply(1'b0, z, 1'b0, 1'b0);

      // Reset state
      #3;
      chk("rst_out_valid", 160'(bus.out_valid), 160'(0));
      chk("rst_in_ready",  160'(bus.in_ready),  160'(1));
      chk("rst_occupancy", 160'(bus.occupancy), 160'(0));
      chk("rst_out_npc",   160'(bus.out_npc),   160'(0));
      chk("rst_out_ctrl",  160'(bus.out_ctrl),  160'(0));
      chk("rst_out_rs",    160'(bus.out_rs),    160'(0));
      repeat (2) @(negedge clk);
      #2 reset = 1'b0;

      // First accept on the first edge after reset; one-cycle latency
      a = rand_ent();
      a.npc  = 32'h0000_0004;
      a.ctrl = 9'h1A5;
      apply(1'b1, a, 1'b1, 1'b0);
      step(1'b0, z, 1'b0, 1'b0);
      chk("lat_out_valid", 160'(bus.out_valid), 160'(1));
      chk("lat_out_npc",   160'(bus.out_npc),   160'(32'h4));
      chk("lat_out_ctrl",  160'(bus.out_ctrl),  160'(9'h1A5));
      chk("lat_occupancy", 160'(bus.occupancy), 160'(1));
      step(1'b0, z, 1'b1, 1'b0);

      // Streaming with out_ready held high
      for (int i = 0; i < 8; i++) begin
         a = rand_ent();
         a.npc = 32'(4 * (i + 1));
         step(1'b1, a, 1'b1, 1'b0);
         chk("stream_in_ready", 160'(bus.in_ready), 160'(1));
      end
      repeat (3) step(1'b0, z, 1'b1, 1'b0);

      // Fill both entries, then drain
      a = rand_ent();
      b = rand_ent();
      step(1'b1, a, 1'b0, 1'b0);
      step(1'b1, b, 1'b0, 1'b0);
      step(1'b0, z, 1'b0, 1'b0);
      chk("full_occupancy", 160'(bus.occupancy), 160'(2));
      chk("full_in_ready",  160'(bus.in_ready),  160'(0));
      chk("full_out_npc",   160'(bus.out_npc),   160'(a.npc));
      repeat (3) step(1'b0, z, 1'b1, 1'b0);
      chk("drain_in_ready", 160'(bus.in_ready), 160'(1));

      // Flush with two held entries and an incoming one
      a = rand_ent();
      b = rand_ent();
      c = rand_ent();
      step(1'b1, a, 1'b0, 1'b0);
      step(1'b1, b, 1'b0, 1'b0);
      step(1'b1, c, 1'b1, 1'b1);
      step(1'b0, z, 1'b0, 1'b0);
      chk("flush_out_valid", 160'(bus.out_valid), 160'(0));
      chk("flush_out_ctrl",  160'(bus.out_ctrl),  160'(0));
      chk("flush_occupancy", 160'(bus.occupancy), 160'(0));
      chk("flush_in_ready",  160'(bus.in_ready),  160'(1));

      // Asynchronous reset between edges with two held entries
      a = rand_ent();
      b = rand_ent();
      a.npc = a.npc | 32'h1;
      step(1'b1, a, 1'b0, 1'b0);
      step(1'b1, b, 1'b0, 1'b0);
      step(1'b0, z, 1'b0, 1'b0);
      chk("pre_arst_occupancy", 160'(bus.occupancy), 160'(2));
      @(posedge clk);
      #3 reset = 1'b1;
      exp_q.delete();
      pend = 1'b0;
      #1;
      chk("arst_out_valid", 160'(bus.out_valid), 160'(0));
      chk("arst_out_npc",   160'(bus.out_npc),   160'(0));
      chk("arst_in_ready",  160'(bus.in_ready),  160'(1));
      chk("arst_occupancy", 160'(bus.occupancy), 160'(0));
      @(negedge clk);
      #2 reset = 1'b0;
      apply(1'b0, z, 1'b0, 1'b0);

      // Random traffic
      for (int i = 0; i < 10000; i++) begin
         step(($urandom_range(0, 9) < 7), rand_ent(), ($urandom_range(0, 9) < 6),
              ($urandom_range(0, 127) == 0));
      end
      repeat (4) step(1'b0, z, 1'b1, 1'b0);
      @(negedge clk);
      #1;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
